// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_driver
// Description : Multiplexes per-digit seven-segment patterns onto a common-
//               anode display (active-low cathodes and anodes). New patterns
//               are double-buffered and take effect only at a frame boundary.
// Revision    : 1.0  initial release
// ============================================================================
module seg_scan_driver #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int IDX_W       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7*DIGITS-1:0]   seg_in,
    input  logic                  load,
    input  logic [DIGITS-1:0]     blank_mask,
    output logic [6:0]            seg_out,
    output logic [DIGITS-1:0]     an,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_done,
    output logic                  pending
);

    localparam int                CNT_W      = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0]  C_IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        C_SEG_OFF  = 7'h7F;

    logic [CNT_W-1:0]      cnt_q,     cnt_d;
    logic [IDX_W-1:0]      idx_q,     idx_d;
    logic [7*DIGITS-1:0]   active_q,  active_d;
    logic [7*DIGITS-1:0]   pbuf_q,    pbuf_d;
    logic                  pending_q, pending_d;
    logic [6:0]            seg_q,     seg_d;
    logic [DIGITS-1:0]     an_q,      an_d;
    logic [IDX_W-1:0]      didx_q;
    logic                  fdone_q;

    logic                  w_tc;
    logic                  w_wrap;

    // Scan timing: each digit holds for REFRESH_DIV cycles, wrap closes a frame.
    always_comb begin
        w_tc   = (cnt_q == C_CNT_LAST);
        w_wrap = w_tc && (idx_q == C_IDX_LAST);

        cnt_d = w_tc ? '0 : cnt_q + CNT_W'(1);

        idx_d = idx_q;
        if (w_tc) begin
            idx_d = w_wrap ? '0 : idx_q + IDX_W'(1);
        end
    end

    // A load coinciding with the wrap bypasses the pending buffer entirely.
    always_comb begin
        active_d  = active_q;
        pbuf_d    = pbuf_q;
        pending_d = pending_q;
        if (w_wrap) begin
            if (load) begin
                active_d  = seg_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                active_d  = pbuf_q;
                pending_d = 1'b0;
            end
        end else if (load) begin
            pbuf_d    = seg_in;
            pending_d = 1'b1;
        end
    end

    always_comb begin
        seg_d = C_SEG_OFF;
        an_d  = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if ((idx_q == IDX_W'(k)) && !blank_mask[k]) begin
                an_d[k] = 1'b0;
                seg_d   = ~active_q[7*k +: 7];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            active_q  <= '0;
            pbuf_q    <= '0;
            pending_q <= 1'b0;
            seg_q     <= C_SEG_OFF;
            an_q      <= '1;
            didx_q    <= '0;
            fdone_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            active_q  <= active_d;
            pbuf_q    <= pbuf_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
            didx_q    <= idx_q;
            fdone_q   <= w_wrap;
        end
    end

    assign seg_out    = seg_q;
    assign an         = an_q;
    assign digit_idx  = didx_q;
    assign frame_done = fdone_q;
    assign pending    = pending_q;

endmodule
`default_nettype wire

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Downstream of the adder/BCD-to-seven-segment path.
- Takes per-digit 7-bit segment patterns and time-multiplexes them onto one shared active-low cathode bus and DIGITS active-low anode lines of a common-anode display.
- Holds a tear-free frame buffer. New patterns take effect only at a frame boundary.

Parameters:
DIGITS, 4, number of multiplexed digits (2..8)
REFRESH_DIV, 100000, clock cycles each digit stays lit; must be >= 2
IDX_W, 2, width of digit index; must satisfy 2**IDX_W >= DIGITS

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
seg_in  input  7*DIGITS  patterns, digit k at bits [7k+6:7k], active-high (1 = segment lit), bit 0 = segment a
load  input  1  one-cycle strobe; capture seg_in
blank_mask  input  DIGITS  1 = digit k dark; sampled live each cycle
seg_out  output  7  cathodes, active-low, registered
an  output  DIGITS  anodes, active-low one-hot, registered
digit_idx  output  IDX_W  index of digit currently driven (matches an)
frame_done  output  1  one-cycle pulse when scan wraps from DIGITS-1 to 0
pending  output  1  1 = captured pattern waiting for frame boundary

Behaviour:
- Reset (rst high at clk edge) sets:
  - refresh counter 0, index 0
  - active buffer and pending buffer all zeros, pending 0
  - an all ones, seg_out 7'h7F, digit_idx 0, frame_done 0
- Refresh counter:
  - counts 0..REFRESH_DIV-1.
  - Terminal count is cnt == REFRESH_DIV-1. On terminal count: cnt <= 0 and idx advances.
  - Advance is idx+1, or 0 when idx == DIGITS-1 (wrap). Unused index codes are never reached.
- Wrap event: terminal count while idx == DIGITS-1.
  - frame_done is registered high for exactly the cycle after the wrap edge.
- Load handling, per clock edge:
  - load and not wrap: pending_buf <= seg_in; pending <= 1. A later load before the boundary overwrites (last wins).
  - wrap and pending and not load: active <= pending_buf; pending <= 0.
  - wrap and load (with or without pending): active <= seg_in directly; pending <= 0. The older pending_buf is discarded.
  - load is level-sampled. Held high for N cycles, it acts as N loads.
- Output stage:
  - Registered from the same-cycle idx, so an/seg_out lag idx by one cycle.
  - digit_idx is the registered copy aligned with an.
  - blank_mask[idx] == 0: an = ~(1 << idx); seg_out = ~active[idx].
  - blank_mask[idx] == 1: an = all ones; seg_out = 7'h7F.
- Each digit is lit for exactly REFRESH_DIV cycles per frame. Frame period = DIGITS*REFRESH_DIV cycles.
- At most one anode is low in any cycle, including immediately after reset.
- Reset mid-frame: counter, index, both buffers and pending clear on that edge. The scan restarts at digit 0 on the next cycle. No frame_done is emitted for the aborted frame.
- Steady state holds the last committed patterns indefinitely without load.

Test Plan:
1. Reset, then run with REFRESH_DIV=4, DIGITS=4 and no load. Require:
   - an cycles 1110, 1101, 1011, 0111, each 4 cycles.
   - seg_out 7'h7F throughout (active all zeros).
   - frame_done pulses every 16 cycles.
2. load=1 for one cycle mid-frame with seg_in={7'h06,7'h5B,7'h4F,7'h66}. Require:
   - pending=1 and outputs unchanged until the wrap.
   - After the wrap: digit0 seg_out 7'h19, digit1 7'h30, digit2 7'h24, digit3 7'h79.
   - pending=0.
3. Two loads in one frame (A then B). Require only B to appear after the boundary; A is never displayed.
4. load asserted exactly on the wrap edge with pending A outstanding, seg_in=B. Require B displayed starting at digit 0 of the next frame, and pending=0.
5. Set blank_mask=4'b0100. Require an=1111 and seg_out=7'h7F during the digit-2 slot, with other slots unaffected and slot timing unchanged.
6. Assert rst for one cycle during digit 2 with pending set. Require:
   - next cycle an=1110, seg_out=7'h7F, pending=0, digit_idx=0.
   - first frame_done exactly 16 cycles later.
